// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit key display: refresh FSM
// state encoding and the active-high hex segment patterns {g,f,e,d,c,b,a}.
package display_pkg;

  typedef enum logic [1:0] {
    SHOW_RIGHT,
    BLANK_R2L,
    SHOW_LEFT,
    BLANK_L2R
  } refresh_state_t;

  // All segments dark, active-high sense.
  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;

endpackage

// File: rtl/seven_seg_decoder.sv
// Purely combinational hex-to-7-segment decode. Output is always the
// active-high pattern; pin polarity is the caller's business.
module seven_seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] pattern
);

  // Table lookup of the glyph for one hex nibble (b and d are lower case).
  always_comb begin
    pattern = SEG_OFF;
    case (hex)
      4'h0: pattern = SEG_HEX_0;
      4'h1: pattern = SEG_HEX_1;
      4'h2: pattern = SEG_HEX_2;
      4'h3: pattern = SEG_HEX_3;
      4'h4: pattern = SEG_HEX_4;
      4'h5: pattern = SEG_HEX_5;
      4'h6: pattern = SEG_HEX_6;
      4'h7: pattern = SEG_HEX_7;
      4'h8: pattern = SEG_HEX_8;
      4'h9: pattern = SEG_HEX_9;
      4'hA: pattern = SEG_HEX_A;
      4'hB: pattern = SEG_HEX_B;
      4'hC: pattern = SEG_HEX_C;
      4'hD: pattern = SEG_HEX_D;
      4'hE: pattern = SEG_HEX_E;
      4'hF: pattern = SEG_HEX_F;
      default: pattern = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/key_digit_display.sv
// Two-digit key history display. The newest key sits on the right digit and
// the one before it on the left. Both common-anode digits share one segment
// bus and are lit in turn, with an optional dark gap between them so the
// previous digit's pattern cannot ghost onto the next one.
module key_digit_display
  import display_pkg::*;
#(
  parameter int REFRESH_DIV    = 150,
  parameter int BLANK_CYCLES   = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int EN_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [6:0] seg,
  output logic [1:0] digit_en,
  output logic [7:0] digits,
  output logic [1:0] digits_loaded
);

  // One counter serves both SHOW and BLANK dwell times, so size it for the longer.
  localparam int MAX_DUR = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit               HAS_BLANK  = (BLANK_CYCLES > 0);

  localparam logic [6:0] SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic [1:0] EN_IDLE  = (EN_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

  refresh_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       shown_hex;
  logic [6:0]       shown_pattern;
  logic [1:0]       lit_mask;
  logic [6:0]       next_seg;
  logic [1:0]       next_en;

  // Two-deep key history: every valid cycle is a fresh key and shifts right into left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits        <= 8'h00;
      digits_loaded <= 2'b00;
    end else if (key_valid) begin
      digits        <= {digits[3:0], key_code};
      digits_loaded <= {digits_loaded[0], 1'b1};
    end
  end

  // The left nibble is only ever shown during SHOW_LEFT; everything else reads right.
  assign shown_hex = (state == SHOW_LEFT) ? digits[7:4] : digits[3:0];

  seven_seg_decoder u_decoder (
    .hex     (shown_hex),
    .pattern (shown_pattern)
  );

  // Pick which digit (if any) is lit this cycle and form the pin-level values.
  always_comb begin
    lit_mask = 2'b00;
    case (state)
      SHOW_RIGHT: if (digits_loaded[0]) lit_mask = 2'b01;
      SHOW_LEFT:  if (digits_loaded[1]) lit_mask = 2'b10;
      default:    lit_mask = 2'b00;
    endcase
    next_seg = (lit_mask != 2'b00) ? shown_pattern : SEG_OFF;
    if (SEG_ACTIVE_LOW != 0) next_seg = ~next_seg;
    next_en = (EN_ACTIVE_LOW != 0) ? ~lit_mask : lit_mask;
  end

  // Refresh sequencer plus the registered pin drivers, which trail the state by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SHOW_RIGHT;
      cnt      <= '0;
      seg      <= SEG_IDLE;
      digit_en <= EN_IDLE;
    end else begin
      seg      <= next_seg;
      digit_en <= next_en;
      case (state)
        SHOW_RIGHT: begin
          if (cnt == SHOW_LAST) begin
            cnt   <= '0;
            state <= HAS_BLANK ? BLANK_R2L : SHOW_LEFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BLANK_R2L: begin
          if (cnt == BLANK_LAST) begin
            cnt   <= '0;
            state <= SHOW_LEFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHOW_LEFT: begin
          if (cnt == SHOW_LAST) begin
            cnt   <= '0;
            state <= HAS_BLANK ? BLANK_L2R : SHOW_RIGHT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BLANK_L2R: begin
          if (cnt == BLANK_LAST) begin
            cnt   <= '0;
            state <= SHOW_RIGHT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= SHOW_RIGHT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_digit_display.sv
// Bench for key_digit_display. Four instances with different timing and
// polarity share one key stream; a cycle-count model predicts every output.
module tb_key_digit_display;

  localparam int R_P [4] = '{150, 4, 4, 3};
  localparam int B_P [4] = '{2, 2, 0, 1};
  localparam bit SAL [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  localparam bit EAL [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic [6:0] DEC [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;

  logic [3:0][6:0] seg_w;
  logic [3:0][1:0] en_w;
  logic [3:0][7:0] dig_w;
  logic [3:0][1:0] ld_w;

  int compared;
  int mismatched;

  int         m_edges;
  int         m_cnt;
  logic [3:0] m_left;
  logic [3:0] m_right;
  logic [6:0] exp_seg [4];
  logic [1:0] exp_en  [4];

  logic [1:0] seq_blank   [12];
  logic [1:0] seq_noblank [8];

  always #5 clk = ~clk;

  key_digit_display #(.REFRESH_DIV(150), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1), .EN_ACTIVE_LOW(1)) u_dut_default (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .seg(seg_w[0]), .digit_en(en_w[0]), .digits(dig_w[0]), .digits_loaded(ld_w[0]));

  key_digit_display #(.REFRESH_DIV(4), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1), .EN_ACTIVE_LOW(1)) u_dut_fast (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .seg(seg_w[1]), .digit_en(en_w[1]), .digits(dig_w[1]), .digits_loaded(ld_w[1]));

  key_digit_display #(.REFRESH_DIV(4), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1), .EN_ACTIVE_LOW(1)) u_dut_noblank (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .seg(seg_w[2]), .digit_en(en_w[2]), .digits(dig_w[2]), .digits_loaded(ld_w[2]));

  key_digit_display #(.REFRESH_DIV(3), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(0), .EN_ACTIVE_LOW(0)) u_dut_high (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .seg(seg_w[3]), .digit_en(en_w[3]), .digits(dig_w[3]), .digits_loaded(ld_w[3]));

  // Position within the refresh period: 0 = right lit, 1 = gap, 2 = left lit.
  function automatic int phase_of(input int k, input int r, input int b);
    int p;
    p = k % (2 * (r + b));
    if (p < r) return 0;
    if (p < r + b) return 1;
    if (p < 2 * r + b) return 2;
    return 1;
  endfunction

  function automatic logic [6:0] expect_seg(input int g, input int k, input int cnt,
                                            input logic [3:0] l, input logic [3:0] r);
    int ph;
    logic [6:0] pat;
    ph  = phase_of(k, R_P[g], B_P[g]);
    pat = 7'h00;
    if (ph == 0 && cnt >= 1) pat = DEC[r];
    else if (ph == 2 && cnt >= 2) pat = DEC[l];
    return SAL[g] ? ~pat : pat;
  endfunction

  function automatic logic [1:0] expect_en(input int g, input int k, input int cnt);
    int ph;
    logic [1:0] mask;
    ph   = phase_of(k, R_P[g], B_P[g]);
    mask = 2'b00;
    if (ph == 0 && cnt >= 1) mask = 2'b01;
    else if (ph == 2 && cnt >= 2) mask = 2'b10;
    return EAL[g] ? ~mask : mask;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drive one key at a negedge; unless held, drop valid, scramble the code, and wait for the pins to catch up.
  task automatic applyStimulus(input logic [3:0] code, input bit hold);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    if (!hold) begin
      key_valid = 1'b0;
      key_code  = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
  endtask

  task automatic wait_phase(input int g, input int ph);
    int budget;
    budget = 0;
    while (!(m_edges >= 1 && phase_of(m_edges - 1, R_P[g], B_P[g]) == ph) && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    if (!(m_edges >= 1 && phase_of(m_edges - 1, R_P[g], B_P[g]) == ph)) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL wait_phase dut%0d: phase %0d not reached, required %0d", g, -1, ph);
    end
  endtask

  task automatic wait_period_start(input int g);
    int budget;
    budget = 0;
    while (!(m_edges >= 1 && (m_edges - 1) % (2 * (R_P[g] + B_P[g])) == 0) && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    if (!(m_edges >= 1 && (m_edges - 1) % (2 * (R_P[g] + B_P[g])) == 0)) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL wait_period_start dut%0d: got no period start, required one within 400 cycles", g);
    end
  endtask

  // Reference model: history as the last two keys, refresh position from the edge count since reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges <= 0;
      m_cnt   <= 0;
      m_left  <= 4'h0;
      m_right <= 4'h0;
      for (int g = 0; g < 4; g++) begin
        exp_seg[g] <= SAL[g] ? 7'h7F : 7'h00;
        exp_en[g]  <= EAL[g] ? 2'b11 : 2'b00;
      end
    end else begin
      for (int g = 0; g < 4; g++) begin
        exp_seg[g] <= expect_seg(g, m_edges, m_cnt, m_left, m_right);
        exp_en[g]  <= expect_en(g, m_edges, m_cnt);
      end
      m_edges <= m_edges + 1;
      if (key_valid) begin
        m_left  <= m_right;
        m_right <= key_code;
        if (m_cnt < 2) m_cnt <= m_cnt + 1;
      end
    end
  end

  // Every negedge, every instance must agree with the model on all four outputs.
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      checkOutput($sformatf("model seg dut%0d edge%0d", g, m_edges), 32'(seg_w[g]), 32'(exp_seg[g]));
      checkOutput($sformatf("model digit_en dut%0d edge%0d", g, m_edges), 32'(en_w[g]), 32'(exp_en[g]));
      checkOutput($sformatf("model digits dut%0d", g), 32'(dig_w[g]), 32'({m_left, m_right}));
      checkOutput($sformatf("model loaded dut%0d", g), 32'(ld_w[g]), 32'({m_cnt >= 2, m_cnt >= 1}));
    end
  end

  // Safety net so a stuck run still ends with a visible failure.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario with hand-computed pin values.
  initial begin
    logic [6:0] inv;
    seq_blank   = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11,
                    2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11};
    seq_noblank = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b1;
    key_valid  = 1'b0;
    key_code   = 4'h0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset seg", 32'(seg_w[0]), 32'h7F);
    checkOutput("reset digit_en", 32'(en_w[0]), 32'h3);
    checkOutput("reset digits", 32'(dig_w[0]), 32'h00);
    checkOutput("reset loaded", 32'(ld_w[0]), 32'h0);
    checkOutput("reset seg active-high", 32'(seg_w[3]), 32'h00);
    checkOutput("reset digit_en active-high", 32'(en_w[3]), 32'h0);
    rst_n = 1'b1;

    repeat (1000) @(negedge clk);
    checkOutput("idle seg", 32'(seg_w[0]), 32'h7F);
    checkOutput("idle digit_en", 32'(en_w[0]), 32'h3);
    checkOutput("idle digits", 32'(dig_w[0]), 32'h00);

    applyStimulus(4'h5, 1'b0);
    checkOutput("key5 digits", 32'(dig_w[0]), 32'h05);
    checkOutput("key5 loaded", 32'(ld_w[0]), 32'h1);
    wait_phase(0, 0);
    checkOutput("key5 right en", 32'(en_w[0]), 32'h2);
    checkOutput("key5 right seg", 32'(seg_w[0]), 32'h12);
    wait_phase(0, 2);
    checkOutput("key5 left en", 32'(en_w[0]), 32'h3);
    checkOutput("key5 left seg", 32'(seg_w[0]), 32'h7F);

    applyStimulus(4'hA, 1'b0);
    checkOutput("keyA digits", 32'(dig_w[0]), 32'h5A);
    checkOutput("keyA loaded", 32'(ld_w[0]), 32'h3);
    wait_phase(0, 2);
    checkOutput("keyA left en", 32'(en_w[0]), 32'h1);
    checkOutput("keyA left seg", 32'(seg_w[0]), 32'h12);
    wait_phase(0, 0);
    checkOutput("keyA right en", 32'(en_w[0]), 32'h2);
    checkOutput("keyA right seg", 32'(seg_w[0]), 32'h08);

    wait_period_start(1);
    for (int i = 0; i < 12; i++) begin
      checkOutput($sformatf("blank seq %0d", i), 32'(en_w[1]), 32'(seq_blank[i]));
      @(negedge clk);
    end
    wait_period_start(2);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("noblank seq %0d", i), 32'(en_w[2]), 32'(seq_noblank[i]));
      @(negedge clk);
    end

    applyStimulus(4'h3, 1'b1);
    applyStimulus(4'h7, 1'b0);
    checkOutput("held digits", 32'(dig_w[0]), 32'h37);
    checkOutput("held loaded", 32'(ld_w[0]), 32'h3);

    wait_phase(0, 2);
    repeat (10) @(negedge clk);
    checkOutput("pre-reset left en", 32'(en_w[0]), 32'h1);
    checkOutput("pre-reset left seg", 32'(seg_w[0]), 32'h30);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset seg", 32'(seg_w[0]), 32'h7F);
    checkOutput("async reset digit_en", 32'(en_w[0]), 32'h3);
    checkOutput("async reset digits", 32'(dig_w[0]), 32'h00);
    checkOutput("async reset loaded", 32'(ld_w[0]), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'h9, 1'b0);
    checkOutput("restart fast en", 32'(en_w[1]), 32'h2);
    checkOutput("restart fast seg", 32'(seg_w[1]), 32'h10);
    checkOutput("restart default en", 32'(en_w[0]), 32'h2);
    checkOutput("restart default digits", 32'(dig_w[0]), 32'h09);

    for (int c = 0; c < 16; c++) begin
      applyStimulus(4'(c), 1'b0);
      wait_phase(1, 0);
      inv = ~DEC[c];
      checkOutput($sformatf("sweep low code %0h", c), 32'(seg_w[1]), 32'(inv));
      wait_phase(3, 0);
      checkOutput($sformatf("sweep high code %0h", c), 32'(seg_w[3]), 32'(DEC[c]));
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
